// File: rtl/vscpu_pkg.sv
// Shared constants, MMIO offsets and responder state encoding for the VerySimpleCPU memory side.
package vscpu_pkg;

  localparam int VS_ADDR_W = 14;
  localparam int VS_DATA_W = 32;

  localparam logic [3:0] MMIO_GPIO   = 4'd0;
  localparam logic [3:0] MMIO_CYCLE  = 4'd1;
  localparam logic [3:0] MMIO_STATUS = 4'd2;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } vs_state_e;

  function automatic logic [VS_DATA_W-1:0] status_word(input logic implicit_q, input logic done_q);
    return {30'b0, implicit_q, done_q};
  endfunction

endpackage

// File: rtl/vscpu_ram_sp.sv
// Single-port synchronous read-first word RAM; 1-cycle read latency, no reset on contents.
module vscpu_ram_sp #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WORDS];
  logic [DW-1:0] rdata_q;

  // Read and write share one address; the read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vscpu_mem_responder.sv
// CPU-facing memory responder: boot loader FSM, RAM, and MMIO (GPIO/cycle counter/status).
// Read data is registered one cycle after the address; the loader is stalled only by leaving LOAD.
module vscpu_mem_responder
  import vscpu_pkg::*;
#(
  parameter int                   MEM_WORDS = 4096,
  parameter logic [VS_ADDR_W-1:0] MMIO_BASE = 14'h3FF0,
  parameter bit                   BOOT_LOAD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [VS_ADDR_W-1:0] addr_toRAM,
  input  logic [VS_DATA_W-1:0] data_toRAM,
  input  logic                 wrEn,
  output logic [VS_DATA_W-1:0] data_fromRAM,
  output logic                 cpu_hold,
  input  logic                 ld_valid,
  input  logic [VS_DATA_W-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic [VS_DATA_W-1:0] gpio_out
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam vs_state_e RST_STATE = BOOT_LOAD ? LOAD : RUN;

  vs_state_e            state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [VS_DATA_W-1:0] cnt_q, cnt_d;
  logic [VS_DATA_W-1:0] gpio_q, gpio_d;
  logic [VS_DATA_W-1:0] mmio_q, mmio_d;
  logic                 sel_ram_q, sel_ram_d;
  logic                 done_q, done_d;
  logic                 impl_q, impl_d;

  logic                 run;
  logic                 in_ram;
  logic                 in_mmio;
  logic [3:0]           mmio_off;
  logic                 ld_fire;
  logic                 ld_final;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [VS_DATA_W-1:0] ram_wdata;
  logic [VS_DATA_W-1:0] ram_rdata;

  assign run      = (state_q == RUN);
  assign in_ram   = (32'(addr_toRAM) < 32'(MEM_WORDS));
  assign in_mmio  = (addr_toRAM[VS_ADDR_W-1:4] == MMIO_BASE[VS_ADDR_W-1:4]);
  assign mmio_off = addr_toRAM[3:0];

  // The last RAM slot ends the load even without ld_last, so ptr never wraps.
  assign ld_fire  = !run && ld_valid;
  assign ld_final = ld_fire && (ld_last || (ptr_q == AW'(MEM_WORDS - 1)));

  assign ram_we    = run ? (wrEn && in_ram) : ld_fire;
  assign ram_addr  = run ? addr_toRAM[AW-1:0] : ptr_q;
  assign ram_wdata = run ? data_toRAM : ld_data;

  vscpu_ram_sp #(
    .WORDS (MEM_WORDS),
    .AW    (AW),
    .DW    (VS_DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gpio_d    = gpio_q;
    done_d    = done_q;
    impl_d    = impl_q;
    sel_ram_d = 1'b0;
    mmio_d    = '0;

    if (!run) begin
      if (ld_fire) begin
        if (ld_final) begin
          state_d = RUN;
          done_d  = 1'b1;
          impl_d  = !ld_last;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
    end else begin
      cnt_d     = cnt_q + 32'd1;
      sel_ram_d = in_ram;
      if (in_mmio) begin
        case (mmio_off)
          MMIO_GPIO:   mmio_d = gpio_q;
          MMIO_CYCLE:  mmio_d = cnt_q;
          MMIO_STATUS: mmio_d = status_word(impl_q, done_q);
          default:     mmio_d = '0;
        endcase
      end
      // A CPU write to CYCLE overrides this edge's increment.
      if (wrEn && in_mmio) begin
        case (mmio_off)
          MMIO_GPIO:  gpio_d = data_toRAM;
          MMIO_CYCLE: cnt_d  = data_toRAM;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gpio_q    <= '0;
      mmio_q    <= '0;
      sel_ram_q <= 1'b0;
      done_q    <= !BOOT_LOAD;
      impl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gpio_q    <= gpio_d;
      mmio_q    <= mmio_d;
      sel_ram_q <= sel_ram_d;
      done_q    <= done_d;
      impl_q    <= impl_d;
    end
  end

  // Both registered sources are forced to zero-select in LOAD and reset, keeping the bus quiet.
  assign data_fromRAM = sel_ram_q ? ram_rdata : mmio_q;
  assign ld_ready     = (state_q == LOAD);
  assign cpu_hold     = (state_q == LOAD);
  assign gpio_out     = gpio_q;

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// Directed bench for vscpu_mem_responder: a 4096-word instance and a 16-word instance.
module tb_vscpu_mem_responder;

  logic        clk;
  int          checks;
  int          errors;

  logic        rst_n;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] rdata;
  logic        hold;
  logic        ldv;
  logic [31:0] ldd;
  logic        ldl;
  logic        ldr;
  logic [31:0] gpio;

  logic        rst16_n;
  logic [13:0] addr16;
  logic [31:0] wdata16;
  logic        wr16;
  logic [31:0] rdata16;
  logic        hold16;
  logic        ldv16;
  logic [31:0] ldd16;
  logic        ldl16;
  logic        ldr16;
  logic [31:0] gpio16;

  vscpu_mem_responder #(.MEM_WORDS(4096), .MMIO_BASE(14'h3FF0), .BOOT_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .addr_toRAM(addr), .data_toRAM(wdata), .wrEn(wr),
    .data_fromRAM(rdata), .cpu_hold(hold), .ld_valid(ldv), .ld_data(ldd),
    .ld_last(ldl), .ld_ready(ldr), .gpio_out(gpio)
  );

  vscpu_mem_responder #(.MEM_WORDS(16), .MMIO_BASE(14'h3FF0), .BOOT_LOAD(1'b1)) dut16 (
    .clk(clk), .rst_n(rst16_n), .addr_toRAM(addr16), .data_toRAM(wdata16), .wrEn(wr16),
    .data_fromRAM(rdata16), .cpu_hold(hold16), .ld_valid(ldv16), .ld_data(ldd16),
    .ld_last(ldl16), .ld_ready(ldr16), .gpio_out(gpio16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; addr = '0; wdata = '0; wr = 1'b0; ldv = 1'b0; ldd = '0; ldl = 1'b0;
    rst16_n = 1'b0; addr16 = '0; wdata16 = '0; wr16 = 1'b0; ldv16 = 1'b0; ldd16 = '0; ldl16 = 1'b0;

    #2;
    chk("rst_data", rdata, 32'h0);
    chk("rst_gpio", gpio, 32'h0);
    chk("rst_hold", {31'b0, hold}, 32'h1);
    chk("rst_ready", {31'b0, ldr}, 32'h1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Boot load of three words, ld_last on the third
    ldv = 1'b1; ldd = 32'h10000005; ldl = 1'b0;
    tick();
    ldd = 32'hD0000000;
    tick();
    ldd = 32'h00000007; ldl = 1'b1;
    chk("load_ready_before_last", {31'b0, ldr}, 32'h1);
    chk("load_data_quiet", rdata, 32'h0);
    tick();
    ldv = 1'b0; ldl = 1'b0;
    chk("load_ready_fall", {31'b0, ldr}, 32'h0);
    chk("load_hold_fall", {31'b0, hold}, 32'h0);

    addr = 14'd0; tick();
    chk("rd_addr0", rdata, 32'h10000005);
    addr = 14'd2; tick();
    chk("rd_addr2", rdata, 32'h00000007);
    addr = 14'd1; tick();
    chk("rd_addr1", rdata, 32'hD0000000);
    addr = 14'h3FF2; tick();
    chk("status_explicit", rdata, 32'h1);

    // Read-first on a same-address write
    addr = 14'd100; wr = 1'b1; wdata = 32'h11111111; tick();
    wdata = 32'hDEADBEEF; tick();
    chk("read_first_old", rdata, 32'h11111111);
    wr = 1'b0; tick();
    chk("read_after_write", rdata, 32'hDEADBEEF);

    // GPIO write and readback
    addr = 14'h3FF0; wr = 1'b1; wdata = 32'h000000A5; tick();
    chk("gpio_out", gpio, 32'h000000A5);
    chk("gpio_read_pre", rdata, 32'h0);
    wr = 1'b0; tick();
    chk("gpio_read", rdata, 32'h000000A5);

    // Hole reads zero and ignores writes (0x2000 must not alias RAM word 0)
    addr = 14'h2000; wr = 1'b1; wdata = 32'h12345678; tick();
    chk("hole_read_wr", rdata, 32'h0);
    wr = 1'b0; tick();
    chk("hole_read", rdata, 32'h0);
    addr = 14'd0; tick();
    chk("hole_no_alias", rdata, 32'h10000005);
    chk("gpio_kept", gpio, 32'h000000A5);

    // Cycle counter write and wrap
    addr = 14'h3FF1; wr = 1'b1; wdata = 32'hFFFFFFFE; tick();
    wr = 1'b0; tick();
    chk("cycle_written", rdata, 32'hFFFFFFFE);
    tick();
    chk("cycle_max", rdata, 32'hFFFFFFFF);
    tick();
    chk("cycle_wrap", rdata, 32'h00000000);
    addr = 14'h3FF5; tick();
    chk("mmio_other", rdata, 32'h0);

    // Asynchronous reset out of RUN
    rst_n = 1'b0; #2;
    chk("arst_hold", {31'b0, hold}, 32'h1);
    chk("arst_ready", {31'b0, ldr}, 32'h1);
    chk("arst_gpio", gpio, 32'h0);
    chk("arst_data", rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a load
    ldv = 1'b1; ldd = 32'hAAAA0000; tick();
    ldd = 32'hBBBB1111; tick();
    ldv = 1'b0;
    rst_n = 1'b0; #2;
    chk("midload_ready", {31'b0, ldr}, 32'h1);
    chk("midload_hold", {31'b0, hold}, 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    ldv = 1'b1; ldd = 32'hCCCC2222; ldl = 1'b1; tick();
    ldv = 1'b0; ldl = 1'b0;
    chk("reload_run", {31'b0, ldr}, 32'h0);
    addr = 14'h3FF1; tick();
    chk("reload_cycle_zero", rdata, 32'h0);
    addr = 14'd0; tick();
    chk("reload_addr0", rdata, 32'hCCCC2222);
    addr = 14'd1; tick();
    chk("reload_addr1", rdata, 32'hBBBB1111);
    addr = 14'h3FF2; tick();
    chk("reload_status", rdata, 32'h1);

    // Implicit last on the 16-word instance
    rst16_n = 1'b1;
    tick();
    ldv16 = 1'b1; ldl16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ldd16 = 32'h100 + 32'(i);
      if (i == 15) chk("impl_ready_w15", {31'b0, ldr16}, 32'h1);
      tick();
    end
    chk("impl_ready_fall", {31'b0, ldr16}, 32'h0);
    chk("impl_hold_fall", {31'b0, hold16}, 32'h0);
    ldd16 = 32'h00000BAD;
    tick();
    ldv16 = 1'b0;
    chk("impl_17th_ready", {31'b0, ldr16}, 32'h0);
    addr16 = 14'h3FF2; tick();
    chk("impl_status", rdata16, 32'h3);
    addr16 = 14'd0; tick();
    chk("impl_addr0", rdata16, 32'h100);
    addr16 = 14'd15; tick();
    chk("impl_addr15", rdata16, 32'h10F);
    addr16 = 14'h0010; tick();
    chk("impl_hole", rdata16, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscpu_mem_responder.md
# vscpu_mem_responder

Memory-side responder for the VerySimpleCPU bus: it answers the CPU's `addr_toRAM`/`wrEn`/`data_toRAM` requests with registered `data_fromRAM` one cycle later. It contains the word RAM, a boot loader that fills RAM over a valid/ready stream while holding the CPU in reset, and a small memory-mapped I/O (MMIO) window. The MMIO window provides a GPIO output register, a cycle counter and a status word. It sits between the CPU core and the top level, replacing a bare RAM model.

## Interface
Parameters:
- `MEM_WORDS`, 4096: number of implemented RAM words (power of two, ≤ `MMIO_BASE`).
- `MMIO_BASE`, 14'h3FF0: first MMIO address; MMIO window spans `MMIO_BASE`..`MMIO_BASE`+15.
- `BOOT_LOAD`, 1: 1 = start in LOAD after reset; 0 = start directly in RUN.

Ports (single clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: async active-low reset.
- `addr_toRAM` in 14: CPU word address.
- `data_toRAM` in 32: CPU write data.
- `wrEn` in 1: CPU write strobe.
- `data_fromRAM` out 32: registered read data.
- `cpu_hold` out 1: drives the CPU's `rst`; high while loading.
- `ld_valid` in 1: loader word valid.
- `ld_data` in 32: loader word.
- `ld_last` in 1: marks the final loader word.
- `ld_ready` out 1: loader may transfer.
- `gpio_out` out 32: GPIO register contents.

## Operation
- The block has two states, LOAD and RUN. Reset enters LOAD if `BOOT_LOAD`=1, otherwise RUN.
- **LOAD state:**
  - `ld_ready`=1 and `cpu_hold`=1.
  - CPU bus inputs are ignored and `data_fromRAM` holds 0.
  - On `ld_valid`&`ld_ready`, `mem[ptr]`←`ld_data` and `ptr`←`ptr`+1; `ptr` resets to 0.
  - Transition to RUN on acceptance of a word with `ld_last`=1, or of the word at `ptr`=`MEM_WORDS`-1 (implicit last, no wrap).
- **RUN state:**
  - `ld_ready`=0 and `cpu_hold`=0.
  - There is no return to LOAD except via reset.
- **RUN read path (every cycle):** `data_fromRAM` is loaded at each edge from the currently presented address.
  - RAM region (addr < `MEM_WORDS`): `mem[addr]`, read-first. A write to the same address in the same cycle returns the old word.
  - Hole (`MEM_WORDS` ≤ addr < `MMIO_BASE`): 0.
  - MMIO offset 0 (GPIO): `gpio_out`.
  - MMIO offset 1 (CYCLE): current counter value.
  - MMIO offset 2 (STATUS): {30'b0, load_implicit, load_done}.
  - Other MMIO offsets: 0.
- **RUN write path (`wrEn`=1):**
  - RAM region: `mem[addr]`←`data_toRAM`.
  - Hole: write ignored.
  - GPIO: `gpio_out`←`data_toRAM`.
  - CYCLE: counter←`data_toRAM`; the write wins over that edge's increment.
  - STATUS and other MMIO offsets: write ignored.
- **Cycle counter:** 32-bit, increments by 1 each RUN edge, wraps 0xFFFFFFFF→0, frozen in LOAD.
- **Status flags:** `load_done` sets on entry to RUN. `load_implicit` sets if the LOAD→RUN transition was caused by memory full without `ld_last`.
- **X tolerance:** the CPU drives X on `addr_toRAM` in idle states. This is harmless when `wrEn`=0. The read data is don't-care, and the block never gates on it.

## Timing
- Read latency is 1 cycle: address in cycle N → `data_fromRAM` valid after edge N+1, matching the CPU's fetch/operand states.
- Writes take effect at the edge that samples `wrEn`=1.
- The final loader acceptance occurs at edge E. At E, the state becomes RUN and `ld_ready`/`cpu_hold` fall together (both are decoded from the state register). The CPU leaves reset at edge E+1 and fetches PC 0.
- Reset values of outputs (asserted asynchronously by `rst_n`=0):
  - `data_fromRAM`=0, `gpio_out`=0.
  - `cpu_hold`=`BOOT_LOAD`, `ld_ready`=`BOOT_LOAD`.
- Reset values of internal state:
  - Counter=0, `ptr`=0.
  - `load_done`=~`BOOT_LOAD`, `load_implicit`=0.
- RAM contents are not cleared by reset.
- Reset mid-load: `ptr` returns to 0 and the already-written words persist; the next load overwrites from address 0.

## Structure
- Package `vscpu_pkg`:
  - Constants `VS_ADDR_W`=14, `VS_DATA_W`=32.
  - MMIO offsets `MMIO_GPIO`=0, `MMIO_CYCLE`=1, `MMIO_STATUS`=2.
  - State enum {LOAD, RUN}.
- Sub-module `vscpu_ram_sp`: single-port, synchronous, read-first RAM (`MEM_WORDS`×32) with write enable. It is inferable as block RAM.
- The top holds the load FSM, the address decode, the MMIO registers and the output mux. The mux selects between the RAM read output and a registered MMIO/hole value, using a registered region select.

## Test plan
- **Boot load:** load 3 words 0x10000005, 0xD0000000, 0x00000007 with `ld_last` on the third.
  - `ld_ready` and `cpu_hold` fall after the third acceptance edge.
  - RAM reads back 0x10000005 at address 0 and 0x00000007 at address 2.
  - STATUS=0x1.
- **Read latency and read-first:**
  - Write 0xDEADBEEF to address 100 while presenting address 100 → `data_fromRAM` next cycle = old value.
  - Next read of address 100 → 0xDEADBEEF.
- **GPIO:** write 0x000000A5 to 0x3FF0 → `gpio_out`=0xA5 after that edge; reading 0x3FF0 returns 0xA5. Reading the hole at 0x2000 returns 0, and a write there has no effect.
- **Counter wrap:** write 0xFFFFFFFE to 0x3FF1 at edge E. Present 0x3FF1 during cycle E+1..E+2 → `data_fromRAM`=0xFFFFFFFF. One cycle later it reads 0x00000000.
- **Implicit last:** with `MEM_WORDS`=16, stream 16 words without `ld_last` → RUN after the 16th word, STATUS=0x3, `ld_ready`=0. A 17th `ld_valid` is not accepted.
- **Reset mid-load:** assert `rst_n`=0 after 2 words are accepted → all outputs return to their reset values asynchronously. Reload 1 word with `ld_last` → address 0 holds the new word and address 1 holds the earlier word.
